// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
// The master drives the word and load; the slave returns the status and the line.
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             busy;
  logic             done;
  logic             d_out;

  modport master (
    output data_in, load,
    input  ready, busy, done, d_out
  );

  modport slave (
    input  data_in, load,
    output ready, busy, done, d_out
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, LSB-first data, optional parity, stop bit.
// Every output is registered, so the line changes on the same edge that accepts a load.
module serial_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  serial_frame_tx_if.slave  bus
);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             parity_reg, parity_next;
  logic             d_out_reg, d_out_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [WIDTH:0]   par_chain;
  logic [WIDTH-1:0] shifted;
  logic             bit_end;
  logic             last_bit;

  // Parity chain seeded with the odd/even selector so the result is the final bit directly.
  assign par_chain[0] = (PARITY_ODD != 0);
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_parity
      assign par_chain[gi+1] = par_chain[gi] ^ bus.data_in[gi];
    end
  endgenerate

  assign shifted  = shift_reg >> 1;
  assign bit_end  = (div_cnt_reg == DIV_W'(DIV - 1));
  assign last_bit = (bit_cnt_reg == BIT_W'(WIDTH - 1));

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    d_out_next   = d_out_reg;
    ready_next   = ready_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    if (state_reg != ST_IDLE) begin
      div_cnt_next = bit_end ? '0 : div_cnt_reg + DIV_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.load) begin
          shift_next   = bus.data_in;
          parity_next  = par_chain[WIDTH];
          state_next   = ST_START;
          d_out_next   = 1'b0;
          ready_next   = 1'b0;
          busy_next    = 1'b1;
          div_cnt_next = '0;
          bit_cnt_next = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          d_out_next = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (!last_bit) begin
            shift_next   = shifted;
            d_out_next   = shifted[0];
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end else if (PARITY_EN != 0) begin
            state_next = ST_PARITY;
            d_out_next = parity_reg;
          end else begin
            state_next = ST_STOP;
            d_out_next = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
          d_out_next = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_next = ST_IDLE;
          d_out_next = 1'b1;
          ready_next = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        d_out_next = 1'b1;
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      d_out_reg   <= 1'b1;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      d_out_reg   <= d_out_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign bus.d_out = d_out_reg;
  assign bus.ready = ready_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx across three parameter sets.
// Each cycle's expected {d_out, busy, ready, done} is queued at load time and popped per edge.
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.WIDTH(8)) ifa ();
  serial_frame_tx_if #(.WIDTH(8)) ifb ();
  serial_frame_tx_if #(.WIDTH(8)) ifc ();

  serial_frame_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  serial_frame_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));
  serial_frame_tx #(.WIDTH(8), .DIV(2), .PARITY_EN(0), .PARITY_ODD(0)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc));

  // Observation vectors: {d_out, busy, ready, done}
  logic [3:0] obs_a, obs_b, obs_c;
  assign obs_a = {ifa.d_out, ifa.busy, ifa.ready, ifa.done};
  assign obs_b = {ifb.d_out, ifb.busy, ifb.ready, ifb.done};
  assign obs_c = {ifc.d_out, ifc.busy, ifc.ready, ifc.done};

  localparam logic [3:0] IDLE_V = 4'b1010;
  localparam logic [3:0] DONE_V = 4'b1011;

  logic [3:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // Queue one whole frame starting at the accepting edge, followed by the done cycle.
  task automatic push_frame(input logic [7:0] data, input int div, input bit pen, input bit podd);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pen) bits.push_back((^data) ^ podd);
    bits.push_back(1'b1);
    foreach (bits[j])
      for (int c = 0; c < div; c++) exp_q.push_back({bits[j], 3'b100});
    exp_q.push_back(DONE_V);
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst = 1'b0;
    ifa.load = 1'b1; ifb.load = 1'b1; ifc.load = 1'b1;
    ifa.data_in = 8'hA5; ifb.data_in = 8'hA5; ifc.data_in = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = IDLE_V;
      compared++;
      if (obs_a !== e) begin mismatched++; $display("FAIL reset_a cyc%0d: got %b expected %b", i, obs_a, e); end
      compared++;
      if (obs_b !== e) begin mismatched++; $display("FAIL reset_b cyc%0d: got %b expected %b", i, obs_b, e); end
      compared++;
      if (obs_c !== e) begin mismatched++; $display("FAIL reset_c cyc%0d: got %b expected %b", i, obs_c, e); end
      if (i == 2) begin
        ifa.load = 1'b0; ifb.load = 1'b0; ifc.load = 1'b0;
        rst = 1'b1;
      end
    end
    $display("test_reset done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_even_a5();
    logic [3:0] e;
    int dones = 0;
    ifa.data_in = 8'hA5; ifa.load = 1'b1;
    @(posedge clk); push_frame(8'hA5, 4, 1'b1, 1'b0); #1; ifa.load = 1'b0;
    for (int i = 0; i < 48; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      if (ifa.done) dones++;
      compared++;
      if (obs_a !== e) begin mismatched++; $display("FAIL even_a5 cyc%0d: got %b expected %b", i, obs_a, e); end
      @(posedge clk); #1;
    end
    compared++;
    if (dones !== 1) begin mismatched++; $display("FAIL even_a5_done_count: got %0d expected 1", dones); end
    $display("test_even_a5 done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_odd_div1();
    logic [3:0] e;
    ifb.data_in = 8'h00; ifb.load = 1'b1;
    @(posedge clk); push_frame(8'h00, 1, 1'b1, 1'b1); #1; ifb.load = 1'b0;
    for (int i = 0; i < 14; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      compared++;
      if (obs_b !== e) begin mismatched++; $display("FAIL odd_div1 cyc%0d: got %b expected %b", i, obs_b, e); end
      @(posedge clk); #1;
    end
    $display("test_odd_div1 done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    ifc.data_in = 8'hFF; ifc.load = 1'b1;
    @(posedge clk);
    // Load stays high, so each re-accept lands on the cycle after done.
    for (int f = 0; f < 3; f++) push_frame(8'hFF, 2, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < 66; i++) begin
      if (i == 42) ifc.load = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      compared++;
      if (obs_c !== e) begin mismatched++; $display("FAIL back_to_back cyc%0d: got %b expected %b", i, obs_c, e); end
      @(posedge clk); #1;
    end
    $display("test_back_to_back done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_ignore_load();
    logic [3:0] e;
    ifa.data_in = 8'hA5; ifa.load = 1'b1;
    @(posedge clk); push_frame(8'hA5, 4, 1'b1, 1'b0); #1; ifa.load = 1'b0;
    for (int i = 0; i < 47; i++) begin
      if (i == 10) begin ifa.data_in = 8'h3C; ifa.load = 1'b1; end
      if (i == 12) ifa.load = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      compared++;
      if (obs_a !== e) begin mismatched++; $display("FAIL ignore_load cyc%0d: got %b expected %b", i, obs_a, e); end
      @(posedge clk); #1;
    end
    $display("test_ignore_load done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  task automatic test_reset_midframe();
    logic [3:0] e;
    ifa.data_in = 8'hA5; ifa.load = 1'b1;
    @(posedge clk); push_frame(8'hA5, 4, 1'b1, 1'b0); #1; ifa.load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      compared++;
      if (obs_a !== e) begin mismatched++; $display("FAIL reset_mid cyc%0d: got %b expected %b", i, obs_a, e); end
      if (i == 15) begin rst = 1'b0; exp_q.delete(); end
      if (i == 16) rst = 1'b1;
      @(posedge clk); #1;
    end
    ifa.data_in = 8'h5A; ifa.load = 1'b1;
    @(posedge clk); push_frame(8'h5A, 4, 1'b1, 1'b0); #1; ifa.load = 1'b0;
    for (int i = 0; i < 47; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      compared++;
      if (obs_a !== e) begin mismatched++; $display("FAIL reset_reload cyc%0d: got %b expected %b", i, obs_a, e); end
      @(posedge clk); #1;
    end
    $display("test_reset_midframe done: compared=%0d mismatched=%0d", compared, mismatched);
  endtask

  initial begin
    ifa.load = 1'b0; ifb.load = 1'b0; ifc.load = 1'b0;
    ifa.data_in = '0; ifb.data_in = '0; ifc.data_in = '0;
    test_reset();
    test_even_a5();
    test_odd_div1();
    test_back_to_back();
    test_ignore_load();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
